muldiv_unit: RTL and testbench

Parametrised successor to the pipeline's combinational ALU-control decode. It decodes the MIPS R-type multiply/divide family (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO) from Funct and runs an iterative multi-cycle multiplier/divider. It owns the HI/LO registers. It sits beside the EX-stage ALU and drives a stall back to the hazard unit while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_iter.sv | 48 ++++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - funct codes and FSM state type for the multiply/divide unit
package muldiv_pkg;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 shift-add multiply / restoring divide datapath
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_next;

    // acc holds {product high, multiplier} when multiplying and {remainder, quotient} when dividing
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, opb};
        if (is_div) begin
            if (!trial[WIDTH])
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            opb <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, a};
            opb <= b;
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - MIPS mult/div decode, iterative FSM, HI/LO ownership and EX stall
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] mf_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               dec_md, dec_any, start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               is_div_r, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   a_orig;
    logic [2*WIDTH-1:0] acc, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign dec_md  = Funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    assign dec_any = dec_md | (Funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    assign stall   = op_valid & dec_any & busy;
    assign start   = op_valid & dec_md & ~flush & (state == ST_IDLE);

    assign a_neg = ~Funct[0] & rs_data[WIDTH-1];
    assign b_neg = ~Funct[0] & rt_data[WIDTH-1];
    assign a_mag = a_neg ? ('0 - rs_data) : rs_data;
    assign b_mag = b_neg ? ('0 - rt_data) : rt_data;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (reset),
        .load   (start),
        .step   (state == ST_CALC),
        .is_div (is_div_r),
        .a      (a_mag),
        .b      (b_mag),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: begin
                if (flush)                    state_next = ST_IDLE;
                else if (cnt == CNT_W'(1))    state_next = ST_FIX;
            end
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            is_div_r <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= '0;
        end else if (start) begin
            cnt      <= CNT_W'(WIDTH);
            is_div_r <= Funct[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (rt_data == '0);
            a_orig   <= rs_data;
        end else if (state == ST_CALC) begin
            cnt <= flush ? '0 : cnt - CNT_W'(1);
        end
    end

    assign prod_fix = neg_q ? ('0 - acc) : acc;
    assign quo_fix  = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

    // MT ops are stalled while busy, so they can never collide with the FIX write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_FIX) begin
            if (!flush) begin
                if (!is_div_r) begin
                    {hi, lo} <= prod_fix;
                end else if (div_zero) begin
                    hi <= a_orig;
                    lo <= '1;
                end else begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end
            end
        end else if (op_valid && !busy) begin
            if (Funct == FN_MTHI) hi <= rs_data;
            if (Funct == FN_MTLO) lo <= rs_data;
        end
    end

    always_comb begin
        mf_result = '0;
        if (Funct == FN_MFHI)      mf_result = hi;
        else if (Funct == FN_MFLO) mf_result = lo;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             op_valid = 1'b0;
    logic [5:0]       Funct = 6'd0;
    logic [WIDTH-1:0] rs_data = '0;
    logic [WIDTH-1:0] rt_data = '0;
    logic             flush = 1'b0;
    logic             busy, stall;
    logic [WIDTH-1:0] mf_result, hi, lo;

    int passed = 0;
    int total = 0;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .Funct     (Funct),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .busy      (busy),
        .stall     (stall),
        .mf_result (mf_result),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference result {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb, q, r;
        sa = a; sb = b;
        sa64 = sa; sb64 = sb;
        case (fn)
            FN_MULT:  return sa64 * sb64;
            FN_MULTU: return {32'd0, a} * {32'd0, b};
            FN_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            FN_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int n;
        e = model(fn, a, b);
        op_valid = 1'b1; Funct = fn; rs_data = a; rt_data = b;
        tick();
        op_valid = 1'b0; Funct = 6'd0;
        n = 0;
        while (busy && n < 100) begin n++; tick(); end
        chk({tag, "_busy"}, 32'(n), 32'(WIDTH + 1));
        chk({tag, "_hi"}, hi, e[63:32]);
        chk({tag, "_lo"}, lo, e[31:0]);
    endtask

    task automatic start_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1; Funct = fn; rs_data = a; rt_data = b;
        tick();
        op_valid = 1'b0; Funct = 6'd0;
    endtask

    initial begin
        logic [31:0] h0, l0, ra, rb;
        logic [5:0]  fns [4];
        logic [5:0]  fn;
        int n;
        fns[0] = FN_MULT; fns[1] = FN_MULTU; fns[2] = FN_DIV; fns[3] = FN_DIVU;

        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        run_op("mult_neg", FN_MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_hi_c", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo_c", lo, 32'hFFFF_FFEB);
        run_op("multu", FN_MULTU, 32'hFFFF_FFFD, 32'd7);
        chk("multu_hi_c", hi, 32'h0000_0006);
        run_op("div_neg", FN_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_lo_c", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi_c", hi, 32'hFFFF_FFFF);
        run_op("divu", FN_DIVU, 32'd100, 32'd7);
        chk("divu_lo_c", lo, 32'd14);
        run_op("divu_zero", FN_DIVU, 32'd5, 32'd0);
        chk("divu_zero_hi_c", hi, 32'd5);
        run_op("div_zero_s", FN_DIV, 32'hFFFF_FFF0, 32'd0);
        run_op("div_min", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_lo_c", lo, 32'h8000_0000);

        op_valid = 1'b1; Funct = FN_MTHI; rs_data = 32'h0000_ABCD;
        tick();
        op_valid = 1'b0; Funct = 6'd0;
        chk("mthi", hi, 32'h0000_ABCD);

        // MFLO held in stall until the multiply has written LO
        start_op(FN_MULT, 32'd6, 32'd9);
        op_valid = 1'b1; Funct = FN_MFLO;
        #0;
        n = 0;
        while (stall && n < 100) begin n++; tick(); end
        chk("mflo_stall_cycles", 32'(n), 32'(WIDTH + 1));
        chk("mflo_result", mf_result, 32'd54);
        op_valid = 1'b0; Funct = 6'd0;

        h0 = hi; l0 = lo;
        start_op(FN_MULT, 32'd5, 32'd5);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_calc_busy", 32'(busy), 32'd0);
        repeat (40) tick();
        chk("flush_calc_hi", hi, h0);
        chk("flush_calc_lo", lo, l0);

        op_valid = 1'b1; Funct = FN_MULT; rs_data = 32'd3; rt_data = 32'd3; flush = 1'b1;
        tick();
        op_valid = 1'b0; Funct = 6'd0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        repeat (40) tick();
        chk("flush_start_lo", lo, l0);

        // flush landing on the FIX cycle must drop the write
        start_op(FN_MULTU, 32'd11, 32'd13);
        repeat (WIDTH) tick();
        chk("fix_still_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_fix_busy", 32'(busy), 32'd0);
        chk("flush_fix_lo", lo, l0);

        start_op(FN_MULT, 32'd1234, 32'd5678);
        repeat (10) tick();
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        run_op("after_rst", FN_MULT, 32'd3, 32'd4);
        chk("after_rst_lo_c", lo, 32'd12);

        for (int i = 0; i < 24; i++) begin
            fn = fns[$urandom_range(0, 3)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom));
            if (i == 0) begin fn = FN_DIV; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            run_op($sformatf("rnd%0d_fn%0h", i, fn), fn, ra, rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
